mch_stack: RTL and testbench
============================

MCH_STACK -- requirements
Module: mch_stack

Interface
REQ-001 Parameter NCH, default 4: number of independent LIFO channels (>=2).
REQ-002 Parameter DPT, default 8: depth per channel (>=2, any integer, not only powers of two).
REQ-003 Parameter DW, default 32: data width.
REQ-004 Parameter AFT, default DPT-1: almost-full threshold, in entries.
REQ-005 Derived constants: CHW = $clog2(NCH); PTRW = $clog2(DPT); level width LVW = PTRW+1.
REQ-006 Port clk, input, 1: clock, all logic on the rising edge.
REQ-007 Port aresetn, input, 1: reset, asynchronous, active-low.
REQ-008 Port i_push_en, input, 1: push request.
REQ-009 Port i_push_ch, input, CHW: target channel of the push.
REQ-010 Port i_push_data, input, DW: push data.
REQ-011 Port i_pop_en, input, 1: pop request.
REQ-012 Port i_pop_ch, input, CHW: channel to pop from and to present on o_pop_data.
REQ-013 Port o_pop_data, output, DW: top item of channel i_pop_ch (combinational read).
REQ-014 Port i_clr_en / i_clr_ch, input, 1 / CHW: synchronous flush of one channel.
REQ-015 Port o_full / o_afull / o_empty, output, NCH each: per-channel status flags.
REQ-016 Port o_level, output, NCH x LVW: per-channel occupancy, range 0..DPT.
REQ-017 Port o_ovf / o_udf, output, NCH each: per-channel sticky overflow and underflow flags.

Function
REQ-018 Each channel SHALL own DPT slots of one shared array of NCH*DPT words; slot address = ch*DPT + index.
REQ-019 o_full[c] SHALL be (level==DPT), o_empty[c] SHALL be (level==0), and o_afull[c] SHALL be (level>=AFT).
REQ-020 A push SHALL be accepted only if the target channel is not full; a pop SHALL be accepted only if the target channel is not empty.
REQ-021 An accepted push SHALL write slot level[c] and increment level by 1 at the next edge.
REQ-022 An accepted pop SHALL decrement level by 1 at the next edge.
REQ-023 o_pop_data SHALL equal slot level-1 of i_pop_ch with zero latency; its value SHALL be don't-care when that channel is empty.
REQ-024 An accepted push and an accepted pop on the same channel in one cycle SHALL overwrite slot level-1 and leave the level unchanged.
REQ-025 An accepted push and an accepted pop on different channels in one cycle SHALL execute independently.
REQ-026 A push to a full channel SHALL be dropped, set o_ovf[c], and leave memory and level unchanged.
REQ-027 A pop from an empty channel SHALL be dropped and set o_udf[c].
REQ-028 A same-channel push and pop when full SHALL be treated as an accepted overwrite (REQ-024), not as an overflow.
REQ-029 i_clr_en SHALL zero level, o_ovf and o_udf of i_clr_ch at the next edge and SHALL override any push or pop to that channel in the same cycle.
REQ-030 A channel select >= NCH SHALL make its request a no-op with no flag change.

Reset
REQ-031 Asserting aresetn low SHALL asynchronously force all levels to 0 and all o_ovf/o_udf to 0, so every channel reads empty with o_full=0 and o_afull=0 (for AFT>0).
REQ-032 Reset SHALL leave memory contents unreset (LUT-RAM friendly).
REQ-033 Release of reset SHALL be synchronised externally; the first accepted operation SHALL occur on the first edge with aresetn high.

Structure
REQ-034 Package stack_pkg SHALL hold the CHW/PTRW/LVW derivation functions and the per-channel status struct (full, afull, empty, ovf, udf).
REQ-035 Sub-module stack_ch_ctrl SHALL implement one channel's level register, flag logic and push/pop/clear qualification; it is generated NCH times.
REQ-036 The top level SHALL hold the shared memory, the address muxes and the pop-data read mux.

Verification
REQ-037 NCH=4, DPT=8: push 0xA0..0xA7 to ch2, then pop 8 -> data 0xA7..0xA0; level 8->0; full then empty; ch0/1/3 stay empty.
REQ-038 Fill ch1, then push 0xDEAD -> o_ovf[1]=1, level 8, top still the last value; then clr ch1 -> level 0, ovf 0.
REQ-039 ch0 holds 3 items; same-cycle push 0x55 and pop on ch0 -> level 3, top 0x55.
REQ-040 Same-cycle push ch0 0x11 and pop ch3 (level 2) -> level[0]+1, level[3]-1, other channel data intact.
REQ-041 Pop on empty ch2 -> o_udf[2]=1, level stays 0; DPT=6, AFT=4: fourth push raises o_afull, sixth push raises o_full.
REQ-042 Assert aresetn mid-burst on ch3 -> all levels 0 and flags cleared immediately; push after release -> level 1, correct data.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the multi-channel LIFO: width derivations and the
// per-channel status bundle.
package stack_pkg;

    // Channel select width; never narrower than one bit.
    function automatic int f_chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Slot index width within one channel.
    function automatic int f_ptrw(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    // Level needs one extra bit so that it can hold DPT itself.
    function automatic int f_lvw(input int d);
        return f_ptrw(d) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic ovf;
        logic udf;
    } stack_status_t;

endpackage

// File: rtl/stack_ch_ctrl.sv
// One LIFO channel: occupancy register, status flags and qualification of
// push, pop and clear requests already decoded for this channel.
module stack_ch_ctrl
    import stack_pkg::*;
#(
    parameter int DPT  = 8,
    parameter int AFT  = DPT - 1,
    parameter int LVW  = f_lvw(DPT),
    parameter int PTRW = f_ptrw(DPT)
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_clr,
    output logic [LVW-1:0]  o_level,
    output stack_status_t   o_status,
    output logic            o_push_acc,
    output logic [PTRW-1:0] o_wr_idx
);

    localparam logic [LVW-1:0] LP_DPT = LVW'(DPT);
    localparam logic [LVW-1:0] LP_AFT = LVW'(AFT);
    localparam logic [LVW-1:0] LP_ONE = LVW'(1);

    logic [LVW-1:0] r_level;
    logic           r_ovf;
    logic           r_udf;
    logic           w_full;
    logic           w_empty;
    logic           w_pop_acc;
    logic           w_push_acc;
    logic           w_push_drop;
    logic           w_pop_drop;

    assign w_full  = (r_level == LP_DPT);
    assign w_empty = (r_level == '0);

    // Clear wins over everything. A pop only needs data present; a push needs
    // room, or a simultaneous accepted pop that frees the top slot (overwrite).
    assign w_pop_acc   = i_pop && !w_empty && !i_clr;
    assign w_push_acc  = i_push && (!w_full || w_pop_acc) && !i_clr;
    assign w_push_drop = i_push && !w_push_acc && !i_clr;
    assign w_pop_drop  = i_pop && w_empty && !i_clr;

    // Overwrite targets the current top slot; a plain push the next free one.
    assign o_wr_idx   = w_pop_acc ? PTRW'(r_level - LP_ONE) : PTRW'(r_level);
    assign o_push_acc = w_push_acc;
    assign o_level    = r_level;

    assign o_status.full  = w_full;
    assign o_status.afull = (r_level >= LP_AFT);
    assign o_status.empty = w_empty;
    assign o_status.ovf   = r_ovf;
    assign o_status.udf   = r_udf;

    // Level and sticky error flags; clear resets all three together.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (i_clr) begin
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_push_acc && !w_pop_acc)
                r_level <= r_level + LP_ONE;
            else if (w_pop_acc && !w_push_acc)
                r_level <= r_level - LP_ONE;
            if (w_push_drop)
                r_ovf <= 1'b1;
            if (w_pop_drop)
                r_udf <= 1'b1;
        end
    end

endmodule

// File: rtl/mch_stack.sv
// Multi-channel LIFO: NCH stacks of DPT words sharing one memory array, with
// a combinational top-of-stack read for the selected pop channel.
module mch_stack
    import stack_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int DPT  = 8,
    parameter  int DW   = 32,
    parameter  int AFT  = DPT - 1,
    localparam int CHW  = f_chw(NCH),
    localparam int PTRW = f_ptrw(DPT),
    localparam int LVW  = f_lvw(DPT)
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     i_push_en,
    input  logic [CHW-1:0]           i_push_ch,
    input  logic [DW-1:0]            i_push_data,
    input  logic                     i_pop_en,
    input  logic [CHW-1:0]           i_pop_ch,
    output logic [DW-1:0]            o_pop_data,
    input  logic                     i_clr_en,
    input  logic [CHW-1:0]           i_clr_ch,
    output logic [NCH-1:0]           o_full,
    output logic [NCH-1:0]           o_afull,
    output logic [NCH-1:0]           o_empty,
    output logic [NCH-1:0][LVW-1:0]  o_level,
    output logic [NCH-1:0]           o_ovf,
    output logic [NCH-1:0]           o_udf
);

    localparam int DEPTH = NCH * DPT;
    localparam int AW    = f_chw(DEPTH);
    localparam logic [LVW-1:0] LP_ONE = LVW'(1);

    logic [DW-1:0]   r_mem [DEPTH];
    stack_status_t   w_status   [NCH];
    logic [PTRW-1:0] w_wr_idx   [NCH];
    logic [NCH-1:0]  w_push_acc;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [AW-1:0]   w_rd_addr;

    // Selects that match no channel decode to nothing, so they are no-ops.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        stack_ch_ctrl #(
            .DPT  (DPT),
            .AFT  (AFT),
            .LVW  (LVW),
            .PTRW (PTRW)
        ) u_ch (
            .clk        (clk),
            .aresetn    (aresetn),
            .i_push     (i_push_en && (i_push_ch == CHW'(g))),
            .i_pop      (i_pop_en  && (i_pop_ch  == CHW'(g))),
            .i_clr      (i_clr_en  && (i_clr_ch  == CHW'(g))),
            .o_level    (o_level[g]),
            .o_status   (w_status[g]),
            .o_push_acc (w_push_acc[g]),
            .o_wr_idx   (w_wr_idx[g])
        );

        assign o_full[g]  = w_status[g].full;
        assign o_afull[g] = w_status[g].afull;
        assign o_empty[g] = w_status[g].empty;
        assign o_ovf[g]   = w_status[g].ovf;
        assign o_udf[g]   = w_status[g].udf;
    end

    // Write address: at most one channel accepts a push in any cycle.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_push_acc[c]) begin
                w_wr_en   = 1'b1;
                w_wr_addr = AW'(c * DPT) + AW'(w_wr_idx[c]);
            end
        end
    end

    // Read address of the selected channel's top; parked at 0 when empty.
    always_comb begin
        w_rd_addr = '0;
        for (int c = 0; c < NCH; c++) begin
            if ((i_pop_ch == CHW'(c)) && !w_status[c].empty)
                w_rd_addr = AW'(c * DPT) + AW'(o_level[c] - LP_ONE);
        end
    end

    assign o_pop_data = r_mem[w_rd_addr];

    // Shared storage, deliberately without reset so it maps onto LUT-RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= i_push_data;
    end

endmodule

// File: tb/tb_mch_stack.sv
// Directed bench for mch_stack: a 4x8 instance for the main behaviour and a
// 3x6 instance (AFT=4) for threshold flags and out-of-range selects.
module tb_mch_stack;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: NCH=4, DPT=8, DW=32
    logic            a_push_en, a_pop_en, a_clr_en;
    logic [1:0]      a_push_ch, a_pop_ch, a_clr_ch;
    logic [31:0]     a_push_data, a_pop_data;
    logic [3:0]      a_full, a_afull, a_empty, a_ovf, a_udf;
    logic [3:0][3:0] a_level;

    // Second DUT: NCH=3, DPT=6, AFT=4, DW=16
    logic            b_push_en, b_pop_en, b_clr_en;
    logic [1:0]      b_push_ch, b_pop_ch, b_clr_ch;
    logic [15:0]     b_push_data, b_pop_data;
    logic [2:0]      b_full, b_afull, b_empty, b_ovf, b_udf;
    logic [2:0][3:0] b_level;

    int n_tot = 0;
    int n_bad = 0;

    mch_stack #(.NCH(4), .DPT(8), .DW(32)) dut_a (
        .clk(clk), .aresetn(aresetn),
        .i_push_en(a_push_en), .i_push_ch(a_push_ch), .i_push_data(a_push_data),
        .i_pop_en(a_pop_en), .i_pop_ch(a_pop_ch), .o_pop_data(a_pop_data),
        .i_clr_en(a_clr_en), .i_clr_ch(a_clr_ch),
        .o_full(a_full), .o_afull(a_afull), .o_empty(a_empty),
        .o_level(a_level), .o_ovf(a_ovf), .o_udf(a_udf)
    );

    mch_stack #(.NCH(3), .DPT(6), .DW(16), .AFT(4)) dut_b (
        .clk(clk), .aresetn(aresetn),
        .i_push_en(b_push_en), .i_push_ch(b_push_ch), .i_push_data(b_push_data),
        .i_pop_en(b_pop_en), .i_pop_ch(b_pop_ch), .o_pop_data(b_pop_data),
        .i_clr_en(b_clr_en), .i_clr_ch(b_clr_ch),
        .o_full(b_full), .o_afull(b_afull), .o_empty(b_empty),
        .o_level(b_level), .o_ovf(b_ovf), .o_udf(b_udf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_push_en = 0; a_pop_en = 0; a_clr_en = 0;
        b_push_en = 0; b_pop_en = 0; b_clr_en = 0;
    endtask

    // Advance one edge and settle at a point away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [1:0] ch, input logic [31:0] d);
        a_push_en = 1; a_push_ch = ch; a_push_data = d;
        tick();
        a_push_en = 0;
    endtask

    task automatic a_peek(input logic [1:0] ch);
        a_pop_ch = ch;
        #1;
    endtask

    task automatic b_push(input logic [1:0] ch, input logic [15:0] d);
        b_push_en = 1; b_push_ch = ch; b_push_data = d;
        tick();
        b_push_en = 0;
    endtask

    initial begin
        idle();
        a_push_ch = 0; a_pop_ch = 0; a_clr_ch = 0; a_push_data = 0;
        b_push_ch = 0; b_pop_ch = 0; b_clr_ch = 0; b_push_data = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", a_level, 16'h0);
        chk("rst_empty", a_empty, 4'hF);
        chk("rst_full",  a_full,  4'h0);
        chk("rst_afull", a_afull, 4'h0);
        chk("rst_flags", {a_ovf, a_udf}, 8'h0);
        aresetn = 1'b1;

        // Fill ch2 with A0..A7, then drain in reverse order
        for (int i = 0; i < 8; i++) a_push(2, 32'hA0 + i);
        chk("ch2_level8", a_level[2], 4'd8);
        chk("ch2_full",   a_full,  4'b0100);
        chk("ch2_afull",  a_afull, 4'b0100);
        chk("ch2_empty",  a_empty, 4'b1011);
        for (int i = 0; i < 8; i++) begin
            a_pop_en = 1; a_pop_ch = 2;
            #1;
            chk($sformatf("ch2_pop%0d", i), a_pop_data, 32'hA7 - i);
            tick();
        end
        a_pop_en = 0;
        chk("ch2_level0", a_level, 16'h0);
        chk("ch2_drained", a_empty, 4'hF);
        chk("ch2_no_udf", a_udf, 4'h0);

        // Overflow on full ch1, then clear (clear also beats a same-cycle push)
        for (int i = 0; i < 8; i++) a_push(1, 32'h10 + i);
        a_push(1, 32'hDEAD);
        a_peek(1);
        chk("ovf_flag",  a_ovf, 4'b0010);
        chk("ovf_level", a_level[1], 4'd8);
        chk("ovf_top",   a_pop_data, 32'h17);
        a_clr_en = 1; a_clr_ch = 1;
        a_push_en = 1; a_push_ch = 1; a_push_data = 32'h99;
        tick();
        idle();
        chk("clr_level", a_level[1], 4'd0);
        chk("clr_ovf",   a_ovf, 4'h0);

        // Same-channel push+pop on ch0 with 3 items overwrites the top
        a_push(0, 32'h1); a_push(0, 32'h2); a_push(0, 32'h3);
        a_push_en = 1; a_push_ch = 0; a_push_data = 32'h55;
        a_pop_en = 1; a_pop_ch = 0;
        tick();
        idle();
        a_peek(0);
        chk("ovw_level", a_level[0], 4'd3);
        chk("ovw_top",   a_pop_data, 32'h55);

        // Push ch0 while popping ch3 in the same cycle
        a_push(3, 32'h31); a_push(3, 32'h32);
        a_push_en = 1; a_push_ch = 0; a_push_data = 32'h11;
        a_pop_en = 1; a_pop_ch = 3;
        tick();
        idle();
        chk("xch_level0", a_level[0], 4'd4);
        chk("xch_level3", a_level[3], 4'd1);
        a_peek(3);
        chk("xch_top3", a_pop_data, 32'h31);
        a_peek(0);
        chk("xch_top0", a_pop_data, 32'h11);

        // Full channel with same-cycle pop is an overwrite, not an overflow
        for (int i = 0; i < 4; i++) a_push(0, 32'h60 + i);
        a_push_en = 1; a_push_ch = 0; a_push_data = 32'h77;
        a_pop_en = 1; a_pop_ch = 0;
        tick();
        idle();
        a_peek(0);
        chk("fovw_level", a_level[0], 4'd8);
        chk("fovw_ovf",   a_ovf, 4'h0);
        chk("fovw_top",   a_pop_data, 32'h77);

        // Underflow on empty ch2
        a_pop_en = 1; a_pop_ch = 2;
        tick();
        idle();
        chk("udf_flag",  a_udf, 4'b0100);
        chk("udf_level", a_level[2], 4'd0);

        // Thresholds on the 6-deep instance with AFT=4
        for (int k = 1; k <= 6; k++) begin
            b_push(0, 16'hB0 + k[15:0]);
            chk($sformatf("b_afull%0d", k), b_afull[0], (k >= 4) ? 1'b1 : 1'b0);
            chk($sformatf("b_full%0d", k),  b_full[0],  (k == 6) ? 1'b1 : 1'b0);
        end
        b_pop_ch = 0;
        #1;
        chk("b_top", b_pop_data, 16'hB6);
        // Select 3 is outside NCH=3: no state or flag may move
        b_push(3, 16'hEEEE);
        b_pop_en = 1; b_pop_ch = 3;
        tick();
        idle();
        chk("b_oor_level", b_level, 12'h006);
        chk("b_oor_flags", {b_ovf, b_udf}, 6'h0);

        // Async reset in the middle of a push burst on ch3
        a_push(3, 32'h40);
        a_push_en = 1; a_push_ch = 3; a_push_data = 32'h41;
        tick();
        a_push_data = 32'h42;
        aresetn = 1'b0;
        #1;
        chk("arst_level", a_level, 16'h0);
        chk("arst_flags", {a_ovf, a_udf}, 8'h0);
        chk("arst_empty", a_empty, 4'hF);
        chk("arst_b_level", b_level, 12'h0);
        idle();
        tick();
        aresetn = 1'b1;
        a_push(3, 32'h77);
        a_peek(3);
        chk("post_level", a_level[3], 4'd1);
        chk("post_data",  a_pop_data, 32'h77);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
